// File: rtl/bus_memory_slave_pkg.sv
// Shared types and widths for the bus memory responder and its begin-cycle decoder.
// Combinational helpers only; no latency or backpressure of its own.
package bus_memory_slave_pkg;

  localparam int DATA_W  = 32;
  localparam int BE_W    = 4;
  localparam int BURST_W = 8;
  localparam int CNT_W   = BURST_W + 1;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WR       = 3'd1,
    ST_RD_FETCH = 3'd2,
    ST_RD_DATA  = 3'd3,
    ST_RD_END   = 3'd4,
    ST_ERR      = 3'd5
  } state_t;

  // Lowest address bit that takes part in window selection.
  function automatic int sel_lsb(input int addr_width);
    return addr_width + 2;
  endfunction

endpackage

// File: rtl/bus_slave_decoder.sv
// Window select and burst range check from the begin-cycle address/burst fields.
// Purely combinational, no backpressure.
module bus_slave_decoder
  import bus_memory_slave_pkg::*;
#(
  parameter logic [31:0] Base      = 32'h5000_0000,
  parameter int          AddrWidth = 9
) (
  input  logic [DATA_W-1:2]    addr_word,
  input  logic [BURST_W-1:0]   burst,
  output logic                 sel,
  output logic [AddrWidth-1:0] word_addr,
  output logic                 range_err
);

  localparam int SelLsb = sel_lsb(AddrWidth);
  localparam int SumW   = ((AddrWidth > BURST_W) ? AddrWidth : BURST_W) + 1;
  localparam logic [SumW-1:0] LastWord = SumW'((1 << AddrWidth) - 1);

  logic [SumW-1:0] last_touched;

  always_comb begin
    sel          = (addr_word[DATA_W-1:SelLsb] == Base[DATA_W-1:SelLsb]);
    word_addr    = addr_word[SelLsb-1:2];
    // Wide sum so a burst running past the top of the buffer is seen, not wrapped.
    last_touched = SumW'(word_addr) + SumW'(burst);
    range_err    = (last_touched > LastWord);
  end

endmodule

// File: rtl/bus_memory_slave.sv
// Bus target serving single/burst reads and writes into a synchronous buffer RAM.
// Reads: first word 2 cycles after begin, then 1 word/cycle, held while busyIN; writes never stall.
module bus_memory_slave
  import bus_memory_slave_pkg::*;
#(
  parameter logic [31:0] Base      = 32'h5000_0000,
  parameter int          AddrWidth = 9
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [DATA_W-1:0]    address_dataIN,
  input  logic [BE_W-1:0]      byte_enableIN,
  input  logic [BURST_W-1:0]   burst_sizeIN,
  input  logic                 read_n_writeIN,
  input  logic                 begin_transactionIN,
  input  logic                 end_transactionIN,
  input  logic                 data_validIN,
  input  logic                 busyIN,
  input  logic                 errorIN,
  output logic [DATA_W-1:0]    address_dataOUT,
  output logic                 data_validOUT,
  output logic                 end_transactionOUT,
  output logic                 busyOUT,
  output logic                 errorOUT,
  output logic [AddrWidth-1:0] bufferAddress,
  output logic [DATA_W-1:0]    dataIn,
  output logic [BE_W-1:0]      byteWriteEnable,
  input  logic [DATA_W-1:0]    dataOut,
  output logic                 transactionDone
);

  localparam logic [AddrWidth-1:0] AddrOne = 1;
  localparam logic [CNT_W-1:0]     CntOne  = 1;

  state_t               state_q, state_d;
  logic [AddrWidth-1:0] addr_q, addr_d;
  logic [BE_W-1:0]      be_q, be_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 done_q, done_d;

  logic                 dec_sel;
  logic                 dec_range_err;
  logic [AddrWidth-1:0] dec_word_addr;
  logic                 sel_begin;
  logic                 wr_word;
  logic                 rd_abort;
  logic                 rd_accept;

  bus_slave_decoder #(
    .Base      (Base),
    .AddrWidth (AddrWidth)
  ) u_decoder (
    .addr_word (address_dataIN[DATA_W-1:2]),
    .burst     (burst_sizeIN),
    .sel       (dec_sel),
    .word_addr (dec_word_addr),
    .range_err (dec_range_err)
  );

  always_comb begin
    sel_begin = begin_transactionIN && dec_sel;
    wr_word   = (state_q == ST_WR) && data_validIN && !errorIN && (count_q != '0);
    rd_abort  = errorIN || end_transactionIN;
    rd_accept = (state_q == ST_RD_DATA) && !rd_abort && !busyIN;
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    be_d    = be_q;
    count_d = count_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (sel_begin) begin
          addr_d  = dec_word_addr;
          be_d    = byte_enableIN;
          count_d = {1'b0, burst_sizeIN} + CntOne;
          if (dec_range_err) state_d = ST_ERR;
          else if (read_n_writeIN) state_d = ST_RD_FETCH;
          else state_d = ST_WR;
        end
      end
      ST_WR: begin
        if (errorIN) begin
          state_d = ST_IDLE;
        end else if (data_validIN && (count_q == '0)) begin
          state_d = ST_ERR;
        end else begin
          if (wr_word) begin
            addr_d  = addr_q + AddrOne;
            count_d = count_q - CntOne;
          end
          if (end_transactionIN) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      ST_RD_FETCH: begin
        state_d = rd_abort ? ST_IDLE : ST_RD_DATA;
      end
      ST_RD_DATA: begin
        if (rd_abort) begin
          state_d = ST_IDLE;
        end else if (rd_accept) begin
          addr_d  = addr_q + AddrOne;
          count_d = count_q - CntOne;
          if (count_q == CntOne) begin
            state_d = ST_RD_END;
            done_d  = 1'b1;
          end
        end
      end
      ST_RD_END: state_d = ST_IDLE;
      ST_ERR:    state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      be_q    <= '0;
      count_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      count_q <= count_d;
      done_q  <= done_d;
    end
  end

  // RAM port is driven straight from state so reset silences it immediately.
  always_comb begin
    address_dataOUT    = '0;
    data_validOUT      = 1'b0;
    end_transactionOUT = 1'b0;
    errorOUT           = 1'b0;
    bufferAddress      = '0;
    dataIn             = '0;
    byteWriteEnable    = '0;
    case (state_q)
      ST_WR: begin
        if (wr_word) begin
          bufferAddress   = addr_q;
          dataIn          = address_dataIN;
          byteWriteEnable = be_q;
        end
      end
      ST_RD_FETCH: bufferAddress = addr_q;
      ST_RD_DATA: begin
        data_validOUT   = 1'b1;
        address_dataOUT = dataOut;
        // Prefetch the next word on accept; re-read the current one while stalled.
        bufferAddress   = busyIN ? addr_q : (addr_q + AddrOne);
      end
      ST_RD_END: end_transactionOUT = 1'b1;
      ST_ERR:    errorOUT = 1'b1;
      default: ;
    endcase
  end

  assign busyOUT         = 1'b0;
  assign transactionDone = done_q;

endmodule

// File: tb/tb_bus_memory_slave.sv
// Directed bench for bus_memory_slave with a behavioural synchronous buffer RAM.
module tb_bus_memory_slave;

  localparam logic [31:0] BASE = 32'h5000_0000;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] address_dataIN;
  logic [3:0]  byte_enableIN;
  logic [7:0]  burst_sizeIN;
  logic        read_n_writeIN, begin_transactionIN, end_transactionIN;
  logic        data_validIN, busyIN, errorIN;
  logic [31:0] address_dataOUT;
  logic        data_validOUT, end_transactionOUT, busyOUT, errorOUT;
  logic [8:0]  bufferAddress;
  logic [31:0] dataIn;
  logic [3:0]  byteWriteEnable;
  logic [31:0] dataOut;
  logic        transactionDone;

  logic [31:0] mem [512];
  logic        pre_vld = 1'b0;
  logic [8:0]  pre_addr = '0;
  logic [31:0] pre_dat = '0;
  logic [81:0] all_out;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  bus_memory_slave #(.Base(BASE), .AddrWidth(9)) dut (
    .clock               (clock),
    .reset               (reset),
    .address_dataIN      (address_dataIN),
    .byte_enableIN       (byte_enableIN),
    .burst_sizeIN        (burst_sizeIN),
    .read_n_writeIN      (read_n_writeIN),
    .begin_transactionIN (begin_transactionIN),
    .end_transactionIN   (end_transactionIN),
    .data_validIN        (data_validIN),
    .busyIN              (busyIN),
    .errorIN             (errorIN),
    .address_dataOUT     (address_dataOUT),
    .data_validOUT       (data_validOUT),
    .end_transactionOUT  (end_transactionOUT),
    .busyOUT             (busyOUT),
    .errorOUT            (errorOUT),
    .bufferAddress       (bufferAddress),
    .dataIn              (dataIn),
    .byteWriteEnable     (byteWriteEnable),
    .dataOut             (dataOut),
    .transactionDone     (transactionDone)
  );

  assign all_out = {address_dataOUT, data_validOUT, end_transactionOUT, busyOUT, errorOUT,
                    bufferAddress, dataIn, byteWriteEnable, transactionDone};

  // Synchronous RAM: read-before-write, byte strobes, plus a bench-side preload port.
  always @(posedge clock) begin
    dataOut <= mem[bufferAddress];
    for (int b = 0; b < 4; b++)
      if (byteWriteEnable[b]) mem[bufferAddress][8*b +: 8] = dataIn[8*b +: 8];
    if (pre_vld) mem[pre_addr] = pre_dat;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic clear_in();
    address_dataIN      = '0;
    byte_enableIN       = '0;
    burst_sizeIN        = '0;
    read_n_writeIN      = 1'b0;
    begin_transactionIN = 1'b0;
    end_transactionIN   = 1'b0;
    data_validIN        = 1'b0;
    busyIN              = 1'b0;
    errorIN             = 1'b0;
  endtask

  task automatic drive_begin(input logic [31:0] a, input logic [7:0] bs, input logic [3:0] be,
                             input logic rnw);
    clear_in();
    begin_transactionIN = 1'b1;
    address_dataIN      = a;
    burst_sizeIN        = bs;
    byte_enableIN       = be;
    read_n_writeIN      = rnw;
  endtask

  task automatic preload(input logic [8:0] a, input logic [31:0] d);
    pre_vld  = 1'b1;
    pre_addr = a;
    pre_dat  = d;
    @(negedge clock);
    pre_vld  = 1'b0;
  endtask

  task automatic test_reset();
    clear_in();
    @(negedge clock);
    drive_begin(BASE, 8'd0, 4'hF, 1'b0);
    #1;
    total++; if (all_out !== '0) begin bad++; $display("FAIL reset_outputs got=%h want=0", all_out); end
    @(negedge clock);
    clear_in();
    reset = 1'b1;
    #1;
    total++; if (all_out !== '0) begin bad++; $display("FAIL reset_release got=%h want=0", all_out); end
    @(negedge clock);
  endtask

  task automatic test_single_write();
    drive_begin(BASE + 32'h10, 8'd0, 4'hF, 1'b0);
    @(negedge clock);
    clear_in();
    address_dataIN = 32'hDEAD_BEEF; data_validIN = 1'b1; end_transactionIN = 1'b1;
    #1;
    total++; if (byteWriteEnable !== 4'hF) begin bad++; $display("FAIL wr_be got=%h want=f", byteWriteEnable); end
    total++; if (bufferAddress !== 9'd4) begin bad++; $display("FAIL wr_addr got=%0d want=4", bufferAddress); end
    total++; if (dataIn !== 32'hDEAD_BEEF) begin bad++; $display("FAIL wr_data got=%h want=deadbeef", dataIn); end
    @(negedge clock);
    clear_in();
    #1;
    total++; if (transactionDone !== 1'b1) begin bad++; $display("FAIL wr_done got=%b want=1", transactionDone); end
    total++; if (mem[4] !== 32'hDEAD_BEEF) begin bad++; $display("FAIL wr_mem got=%h want=deadbeef", mem[4]); end
    @(negedge clock);
    #1;
    total++; if (transactionDone !== 1'b0) begin bad++; $display("FAIL wr_done_pulse got=%b want=0", transactionDone); end
  endtask

  task automatic test_burst_read(input bit stall);
    logic [31:0] want;
    int n;
    for (int i = 0; i < 4; i++) preload(9'(i), 32'(i + 1));
    n = stall ? 5 : 4;
    drive_begin(BASE, 8'd3, 4'h0, 1'b1);
    @(negedge clock);
    clear_in();
    #1;
    total++; if (data_validOUT !== 1'b0 || bufferAddress !== 9'd0)
      begin bad++; $display("FAIL rd_fetch vld=%b addr=%0d want vld=0 addr=0", data_validOUT, bufferAddress); end
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      busyIN = stall && (i == 1);
      want = (stall && i >= 2) ? 32'(i) : 32'(i + 1);
      #1;
      total++; if (data_validOUT !== 1'b1 || address_dataOUT !== want || end_transactionOUT !== 1'b0)
        begin bad++; $display("FAIL rd_beat%0d stall=%0d vld=%b dat=%h end=%b want vld=1 dat=%h end=0",
                              i, stall, data_validOUT, address_dataOUT, end_transactionOUT, want); end
    end
    @(negedge clock);
    busyIN = 1'b0;
    #1;
    total++; if (end_transactionOUT !== 1'b1 || data_validOUT !== 1'b0 || transactionDone !== 1'b1)
      begin bad++; $display("FAIL rd_end stall=%0d end=%b vld=%b done=%b want 1 0 1",
                            stall, end_transactionOUT, data_validOUT, transactionDone); end
    @(negedge clock);
    #1;
    total++; if (all_out !== '0) begin bad++; $display("FAIL rd_idle_after got=%h want=0", all_out); end
  endtask

  task automatic test_range_error();
    drive_begin(BASE + 32'h7FC, 8'd1, 4'hF, 1'b1);
    @(negedge clock);
    clear_in();
    #1;
    total++; if (errorOUT !== 1'b1 || byteWriteEnable !== 4'h0 || data_validOUT !== 1'b0)
      begin bad++; $display("FAIL range_err err=%b be=%h vld=%b want 1 0 0", errorOUT, byteWriteEnable, data_validOUT); end
    @(negedge clock);
    #1;
    total++; if (all_out !== '0) begin bad++; $display("FAIL range_err_idle got=%h want=0", all_out); end
    preload(9'h1FF, 32'hCAFE_0001);
    drive_begin(BASE + 32'h7FC, 8'd0, 4'h0, 1'b1);
    @(negedge clock);
    clear_in();
    #1;
    total++; if (errorOUT !== 1'b0 || bufferAddress !== 9'h1FF)
      begin bad++; $display("FAIL top_word_fetch err=%b addr=%h want 0 1ff", errorOUT, bufferAddress); end
    @(negedge clock);
    #1;
    total++; if (data_validOUT !== 1'b1 || address_dataOUT !== 32'hCAFE_0001)
      begin bad++; $display("FAIL top_word_data vld=%b dat=%h want 1 cafe0001", data_validOUT, address_dataOUT); end
    @(negedge clock);
    @(negedge clock);
  endtask

  task automatic test_unselected();
    drive_begin(32'h4000_0000, 8'd0, 4'hF, 1'b0);
    for (int i = 0; i < 4; i++) begin
      #1;
      total++; if (all_out !== '0) begin bad++; $display("FAIL unsel_cycle%0d got=%h want=0", i, all_out); end
      @(negedge clock);
      clear_in();
      address_dataIN = 32'h0BAD_0000 + 32'(i); data_validIN = 1'b1; end_transactionIN = 1'b1;
    end
    clear_in();
  endtask

  task automatic test_abort();
    drive_begin(BASE, 8'd3, 4'h0, 1'b1);
    @(negedge clock);
    clear_in();
    @(negedge clock);
    #1;
    total++; if (data_validOUT !== 1'b1 || address_dataOUT !== 32'd1)
      begin bad++; $display("FAIL abort_first vld=%b dat=%h want 1 1", data_validOUT, address_dataOUT); end
    @(negedge clock);
    errorIN = 1'b1;
    @(negedge clock);
    clear_in();
    for (int i = 0; i < 2; i++) begin
      #1;
      total++; if (all_out !== '0) begin bad++; $display("FAIL abort_quiet%0d got=%h want=0", i, all_out); end
      @(negedge clock);
    end
    drive_begin(BASE + 32'h8, 8'd0, 4'h0, 1'b1);
    @(negedge clock);
    clear_in();
    @(negedge clock);
    #1;
    total++; if (data_validOUT !== 1'b1 || address_dataOUT !== 32'd3)
      begin bad++; $display("FAIL abort_next_data vld=%b dat=%h want 1 3", data_validOUT, address_dataOUT); end
    @(negedge clock);
    #1;
    total++; if (end_transactionOUT !== 1'b1 || transactionDone !== 1'b1)
      begin bad++; $display("FAIL abort_next_end end=%b done=%b want 1 1", end_transactionOUT, transactionDone); end
    @(negedge clock);
  endtask

  task automatic test_partial_write();
    preload(9'd6, 32'h1122_3344);
    drive_begin(BASE + 32'h18, 8'd0, 4'b0011, 1'b0);
    @(negedge clock);
    clear_in();
    address_dataIN = 32'hAABB_CCDD; data_validIN = 1'b1; end_transactionIN = 1'b1;
    #1;
    total++; if (byteWriteEnable !== 4'b0011 || bufferAddress !== 9'd6)
      begin bad++; $display("FAIL partial_strobe be=%b addr=%0d want 0011 6", byteWriteEnable, bufferAddress); end
    @(negedge clock);
    clear_in();
    #1;
    total++; if (mem[6] !== 32'h1122_CCDD) begin bad++; $display("FAIL partial_mem got=%h want=1122ccdd", mem[6]); end
    @(negedge clock);
  endtask

  task automatic test_back_to_back();
    drive_begin(BASE + 32'h40, 8'd1, 4'hF, 1'b0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      clear_in();
      address_dataIN = 32'hA0 + 32'(i); data_validIN = 1'b1; end_transactionIN = (i == 1);
      #1;
      total++; if (bufferAddress !== 9'(16 + i) || byteWriteEnable !== 4'hF)
        begin bad++; $display("FAIL b2b_word%0d addr=%0d be=%h want %0d f", i, bufferAddress, byteWriteEnable, 16 + i); end
    end
    @(negedge clock);
    clear_in();
    #1;
    total++; if (transactionDone !== 1'b1 || mem[16] !== 32'hA0 || mem[17] !== 32'hA1)
      begin bad++; $display("FAIL b2b_done done=%b m16=%h m17=%h want 1 a0 a1", transactionDone, mem[16], mem[17]); end
    @(negedge clock);
  endtask

  task automatic test_write_overrun();
    drive_begin(BASE + 32'h80, 8'd0, 4'hF, 1'b0);
    @(negedge clock);
    clear_in();
    address_dataIN = 32'h5555_0000; data_validIN = 1'b1;
    @(negedge clock);
    address_dataIN = 32'h5555_0001;
    #1;
    total++; if (byteWriteEnable !== 4'h0) begin bad++; $display("FAIL overrun_strobe got=%h want=0", byteWriteEnable); end
    @(negedge clock);
    clear_in();
    #1;
    total++; if (errorOUT !== 1'b1 || transactionDone !== 1'b0)
      begin bad++; $display("FAIL overrun_err err=%b done=%b want 1 0", errorOUT, transactionDone); end
    @(negedge clock);
    #1;
    total++; if (all_out !== '0) begin bad++; $display("FAIL overrun_idle got=%h want=0", all_out); end
    @(negedge clock);
  endtask

  task automatic test_reset_mid_write();
    drive_begin(BASE + 32'h20, 8'd3, 4'hF, 1'b0);
    @(negedge clock);
    clear_in();
    address_dataIN = 32'h1234_5678; data_validIN = 1'b1;
    #1;
    total++; if (byteWriteEnable !== 4'hF) begin bad++; $display("FAIL midrst_pre be=%h want=f", byteWriteEnable); end
    #1;
    reset = 1'b0;
    #1;
    total++; if (all_out !== '0) begin bad++; $display("FAIL midrst_outputs got=%h want=0", all_out); end
    @(negedge clock);
    reset = 1'b1;
    #1;
    total++; if (all_out !== '0) begin bad++; $display("FAIL midrst_idle got=%h want=0", all_out); end
    @(negedge clock);
    clear_in();
  endtask

  initial begin
    clear_in();
    test_reset();
    test_single_write();
    test_burst_read(1'b0);
    test_burst_read(1'b1);
    test_range_error();
    test_unselected();
    test_abort();
    test_partial_write();
    test_back_to_back();
    test_write_overrun();
    test_reset_mid_write();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bus_memory_slave.md
Name: bus_memory_slave

Overview:
- Bus responder (target) for the shared transaction bus, which DMA initiators use to reach a local 2^AddrWidth x 32 buffer RAM.
- Decodes begin_transaction against Base.
- Serves single and burst reads/writes through the synchronous buffer port.
- Drives data, end, busy and error back to the initiator.
- Sits beside the buffer RAM, opposite the DMA on the bus.

Parameters:
- Base, 32'h50000000, byte base address of the window; low AddrWidth+2 bits are zero.
- AddrWidth, 9, buffer word-address width; window size = 4*2^AddrWidth bytes.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- address_dataIN  in  32  address in the begin cycle, write data otherwise.
- byte_enableIN  in  4  byte lanes for writes, latched at begin.
- burst_sizeIN  in  8  burst length minus one, in words, latched at begin.
- read_n_writeIN  in  1  1 = read, latched at begin.
- begin_transactionIN  in  1  start of transaction.
- end_transactionIN  in  1  initiator ends a write, or aborts.
- data_validIN  in  1  write word present.
- busyIN  in  1  initiator stalls read data.
- errorIN  in  1  bus-level error, aborts.
- address_dataOUT  out  32  read data.
- data_validOUT  out  1  read word present.
- end_transactionOUT  out  1  read burst complete.
- busyOUT  out  1  target stall.
- errorOUT  out  1  target error.
- bufferAddress  out  AddrWidth  RAM word address.
- dataIn  out  32  RAM write data.
- byteWriteEnable  out  4  per-byte RAM write strobes.
- dataOut  in  32  RAM read data, valid 1 cycle after address.
- transactionDone  out  1  1-cycle pulse per completed, non-aborted transaction.

Behaviour:
- Reset (reset=0, any time, including mid-burst):
  - State goes to IDLE.
  - All outputs are 0.
  - Latched address, byte enable and count are cleared.
- Select condition: begin_transactionIN=1 and address_dataIN[31:AddrWidth+2] == Base[31:AddrWidth+2]. Unselected transactions are ignored entirely; outputs stay 0.
- Latched at a selected begin:
  - word address = address_dataIN[AddrWidth+1:2]
  - count = burst_sizeIN + 1, 9-bit
  - byte enables and read_n_write
- Range check: if word address + burst_sizeIN > 2^AddrWidth-1, go to ERR. No RAM access occurs.
- ERR state: errorOUT=1 for exactly 1 cycle, then IDLE.
- States: IDLE, WR, RD_FETCH, RD_DATA, RD_END, ERR.
- IDLE → WR, RD_FETCH or ERR on a selected begin. Otherwise stay in IDLE.
- WR:
  - busyOUT=0.
  - Each cycle with data_validIN=1:
    - bufferAddress = current address, dataIn = address_dataIN, byteWriteEnable = latched byte enables (same lanes for every word of the burst).
    - Address increments by 1, count decrements.
  - A data_validIN while count==0 (overrun): go to ERR, no write.
  - end_transactionIN=1 → IDLE with a transactionDone pulse. A word with data_validIN in that same cycle is still written.
  - byteWriteEnable=0 in every state except WR with data_validIN=1.
- RD_FETCH: drive bufferAddress = start address for 1 cycle, then RD_DATA.
- RD_DATA:
  - data_validOUT=1, address_dataOUT = dataOut.
  - A word is accepted when busyIN=0.
  - On accept, drive bufferAddress = address+1, increment the address, decrement count.
  - While busyIN=1, drive bufferAddress = address so dataOut holds the same word.
  - Full throughput: 1 word/cycle when not stalled.
  - Accept with count==1 → RD_END.
- RD_END: end_transactionOUT=1 and data_validOUT=0 for 1 cycle, transactionDone=1, then IDLE.
- Read latency: first data_validOUT appears 2 cycles after the begin cycle.
- Abort: errorIN=1 or end_transactionIN=1 during RD_FETCH/RD_DATA:
  - Go to IDLE next cycle.
  - No end_transactionOUT, no transactionDone.
  - errorIN in WR → IDLE, no transactionDone.
- A begin_transactionIN outside IDLE is ignored.
- Address arithmetic is AddrWidth-bit. No wrap can occur because of the range check.

Decomposition:
- Shared package holds:
  - state encoding constants (IDLE..ERR)
  - bus field widths (data 32, byte enable 4, burst 8)
  - a helper constant for the window-select bit range
- One natural sub-module: bus_slave_decoder (select match plus range check, purely combinational from the begin-cycle fields). Everything else stays in the top FSM.

Test Plan:
- Single write: begin addr=Base+0x10, burst 0, be=4'hF, write; next cycle data 32'hDEADBEEF with data_valid and end → byteWriteEnable=F at bufferAddress=4, dataIn=DEADBEEF, transactionDone pulse.
- Burst read, 4 words, from Base+0x0 with RAM preloaded 1,2,3,4 → data_validOUT on cycles +2..+5 with values 1,2,3,4; end_transactionOUT at +6; transactionDone pulse.
- Same read with busyIN=1 on the 2nd data cycle → value 2 held for 2 cycles; sequence still 1,2,3,4; end shifts by 1 cycle.
- Range error: begin addr=Base+0x7FC, burst 1 → errorOUT=1 for one cycle at +1; no RAM strobes; IDLE afterwards.
- Unselected address 32'h40000000 → all outputs 0 throughout.
- Abort and reset:
  - errorIN mid read burst → no end_transactionOUT; next begin is accepted normally.
  - reset low mid write → all outputs 0 immediately.
- Partial-lane write: be=4'b0011, data 32'hAABBCCDD → only bytes 0-1 are written.
